// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and the next-PC select encoding for the
// program-counter generator and its return-address stack.
//   DEF_RESET_VEC / DEF_EXC_VEC / DEF_INC : default parameter values.
//   pc_sel_e                              : which source feeds the PC register.
package pc_pkg;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int unsigned DEF_INC       = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  // Listed lowest to highest priority.
  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_RAS,
    SEL_REDIR,
    SEL_ERET,
    SEL_EXC
  } pc_sel_e;

endpackage

// File: rtl/pc_gen_ras.sv
// ras_stack: circular return-address stack.
// Ports:
//   i_clk, i_reset   : clock, asynchronous active-high reset
//   i_push           : write i_push_addr as the new top
//   i_pop            : remove the top (ignored when empty)
//   i_flush          : discard all entries (wins over push/pop)
//   i_push_addr      : address pushed by a call
//   o_top            : top entry, 0 when empty
//   o_count          : number of valid entries (saturates at RAS_DEPTH)
//   o_empty          : no valid entries
// Push together with pop on a non-empty stack replaces the top in place.
// Pushing while full overwrites the oldest entry, which is the slot the
// write pointer already points at once the buffer has wrapped.
module ras_stack
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_push,
  input  logic                               i_pop,
  input  logic                               i_flush,
  input  logic [WIDTH-1:0]                   i_push_addr,
  output logic [WIDTH-1:0]                   o_top,
  output logic [$clog2(RAS_DEPTH+1)-1:0]     o_count,
  output logic                               o_empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;    // next slot to write
  logic [CW-1:0]    r_count;

  logic [PW-1:0]    w_top_idx;
  logic             w_empty;
  logic             w_full;

  assign w_top_idx = r_ptr - PTR_ONE;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_MAX);

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_count = r_count;
  assign o_empty = w_empty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      for (int i = 0; i < int'(RAS_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (i_push && i_pop && !w_empty) begin
      r_mem[w_top_idx] <= i_push_addr;
    end else if (i_push) begin
      r_mem[r_ptr] <= i_push_addr;
      r_ptr        <= r_ptr + PTR_ONE;
      if (!w_full) begin
        r_count <= r_count + CNT_ONE;
      end
    end else if (i_pop && !w_empty) begin
      r_ptr   <= w_top_idx;
      r_count <= r_count - CNT_ONE;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch program-counter generator.
// Ports:
//   clk, reset      : clock, asynchronous active-high reset
//   en              : 1 advances the PC, 0 stalls (exc/eret still act)
//   redirect_valid  : decode-resolved branch/jump, target redirect_pc
//   exc_valid       : exception taken, PC -> EXC_VEC, RAS flushed
//   eret_valid      : exception return, PC -> epc_in
//   call, push_addr : push link address onto the RAS
//   ret             : predict return target from the RAS top
//   pc              : registered fetch PC
//   pc_plus         : pc + INC (wraps modulo 2^WIDTH)
//   ras_top, ras_empty, ras_count : RAS status
// Priority: exc > eret > redirect > RAS pop > sequential > hold.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0]  EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int unsigned       INC       = DEF_INC,
  parameter int unsigned       RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            en,
  input  logic                            redirect_valid,
  input  logic [WIDTH-1:0]                redirect_pc,
  input  logic                            exc_valid,
  input  logic                            eret_valid,
  input  logic [WIDTH-1:0]                epc_in,
  input  logic                            call,
  input  logic [WIDTH-1:0]                push_addr,
  input  logic                            ret,
  output logic [WIDTH-1:0]                pc,
  output logic [WIDTH-1:0]                pc_plus,
  output logic [WIDTH-1:0]                ras_top,
  output logic                            ras_empty,
  output logic [$clog2(RAS_DEPTH+1)-1:0]  ras_count
);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] w_pc_plus;
  logic [WIDTH-1:0] w_ras_top;
  logic             w_ras_empty;
  logic             w_ras_op;
  logic             w_push;
  logic             w_pop;
  pc_sel_e          w_sel;

  assign w_pc_plus = r_pc + WIDTH'(INC);

  // Stack operations only happen on an advancing, non-exceptional cycle.
  // A pop alongside a redirect still happens so the RAS stays in step
  // with the call/return nesting even when decode overrides the PC.
  assign w_ras_op = en && !exc_valid && !eret_valid;
  assign w_push   = w_ras_op && call;
  assign w_pop    = w_ras_op && ret;

  ras_stack #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_flush     (exc_valid),
    .i_push_addr (push_addr),
    .o_top       (w_ras_top),
    .o_count     (ras_count),
    .o_empty     (w_ras_empty)
  );

  always_comb begin
    w_sel = SEL_HOLD;
    if (exc_valid) begin
      w_sel = SEL_EXC;
    end else if (eret_valid) begin
      w_sel = SEL_ERET;
    end else if (redirect_valid && en) begin
      w_sel = SEL_REDIR;
    end else if (ret && en && !w_ras_empty) begin
      w_sel = SEL_RAS;
    end else if (en) begin
      w_sel = SEL_SEQ;
    end
  end

  always_comb begin
    w_pc_next = r_pc;
    case (w_sel)
      SEL_EXC:   w_pc_next = EXC_VEC;
      SEL_ERET:  w_pc_next = epc_in;
      SEL_REDIR: w_pc_next = redirect_pc;
      SEL_RAS:   w_pc_next = w_ras_top;
      SEL_SEQ:   w_pc_next = w_pc_plus;
      default:   w_pc_next = r_pc;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_VEC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign pc        = r_pc;
  assign pc_plus   = w_pc_plus;
  assign ras_top   = w_ras_top;
  assign ras_empty = w_ras_empty;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

  localparam int CW = 3;

  // Clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit DUT signals
  logic        en, redirect_valid, exc_valid, eret_valid, call, ret;
  logic [31:0] redirect_pc, epc_in, push_addr;
  logic [31:0] pc, pc_plus, ras_top;
  logic        ras_empty;
  logic [CW-1:0] ras_count;

  // 16-bit DUT signals
  logic        en16, call16, ret16;
  logic [15:0] push_addr16;
  logic [15:0] pc16, pc_plus16, ras_top16;
  logic        ras_empty16;
  logic [CW-1:0] ras_count16;

  pc_gen dut (
    .clk(clk), .reset(reset), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .eret_valid(eret_valid), .epc_in(epc_in),
    .call(call), .push_addr(push_addr), .ret(ret),
    .pc(pc), .pc_plus(pc_plus), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_count(ras_count)
  );

  pc_gen #(.WIDTH(16), .RESET_VEC(16'hFFF8), .EXC_VEC(16'h0180)) dut16 (
    .clk(clk), .reset(reset), .en(en16),
    .redirect_valid(1'b0), .redirect_pc(16'h0000),
    .exc_valid(1'b0), .eret_valid(1'b0), .epc_in(16'h0000),
    .call(call16), .push_addr(push_addr16), .ret(ret16),
    .pc(pc16), .pc_plus(pc_plus16), .ras_top(ras_top16),
    .ras_empty(ras_empty16), .ras_count(ras_count16)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    en = 0; redirect_valid = 0; exc_valid = 0; eret_valid = 0;
    call = 0; ret = 0; redirect_pc = '0; epc_in = '0; push_addr = '0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        en, redir, exc, eret, call, ret;
    logic [31:0] rpc, epc, paddr;
    logic [31:0] exp_pc;
    logic [CW-1:0] exp_cnt;
    logic [31:0] exp_top;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic e, input logic rd, input logic [31:0] rpc,
                              input logic ex, input logic er, input logic [31:0] epc,
                              input logic c, input logic [31:0] pa, input logic r,
                              input logic [31:0] xpc, input int xcnt, input logic [31:0] xtop);
    vec_t v;
    v.en = e; v.redir = rd; v.rpc = rpc; v.exc = ex; v.eret = er; v.epc = epc;
    v.call = c; v.paddr = pa; v.ret = r;
    v.exp_pc = xpc; v.exp_cnt = CW'(xcnt); v.exp_top = xtop;
    tbl.push_back(v);
  endfunction

  initial begin
    clear_inputs();
    en16 = 0; call16 = 0; ret16 = 0; push_addr16 = '0;

    //         en rd rpc       ex er epc       call paddr     ret  exp_pc    cnt top
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    0, 32'h3004, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    0, 32'h3008, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    0, 32'h300C, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    0, 32'h3010, 0, 32'h0);
    add(0, 1, 32'h3100, 0, 0, 32'h0,    0, 32'h0,    0, 32'h3010, 0, 32'h0);  // stalled redirect ignored
    add(0, 0, 32'h0,    1, 0, 32'h0,    0, 32'h0,    0, 32'h4180, 0, 32'h0);  // exc while stalled
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h3024, 0, 32'h4184, 1, 32'h3024);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h3024, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h3028, 0, 32'h0);  // ret on empty
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h5000, 0, 32'h302C, 1, 32'h5000);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h5010, 0, 32'h3030, 2, 32'h5010);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h5020, 0, 32'h3034, 3, 32'h5020);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h5030, 0, 32'h3038, 4, 32'h5030);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h5040, 0, 32'h303C, 4, 32'h5040);  // full: overwrite oldest
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h5040, 3, 32'h5030);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h5030, 2, 32'h5020);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h5020, 1, 32'h5010);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h5010, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h5014, 0, 32'h0);   // fifth ret sequential
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6000, 0, 32'h5018, 1, 32'h6000);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6010, 0, 32'h501C, 2, 32'h6010);
    add(1, 1, 32'h3100, 1, 1, 32'h7000, 1, 32'h6020, 0, 32'h4180, 0, 32'h0);  // exc wins, flush
    add(0, 0, 32'h0,    0, 1, 32'h3040, 0, 32'h0,    0, 32'h3040, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6100, 0, 32'h3044, 1, 32'h6100);
    add(1, 1, 32'h3200, 0, 0, 32'h0,    0, 32'h0,    1, 32'h3200, 0, 32'h0);   // redirect + pop
    add(1, 1, 32'h3300, 0, 0, 32'h0,    1, 32'h6200, 0, 32'h3300, 1, 32'h6200); // redirect + push
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6300, 1, 32'h6200, 1, 32'h6300); // call+ret replace
    add(0, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6999, 1, 32'h6200, 1, 32'h6300); // stall holds RAS
    add(1, 0, 32'h0,    0, 1, 32'h3400, 1, 32'h6888, 0, 32'h3400, 1, 32'h6300); // eret: no push
    add(1, 0, 32'h0,    0, 0, 32'h0,    0, 32'h0,    1, 32'h6300, 0, 32'h0);
    add(1, 0, 32'h0,    0, 0, 32'h0,    1, 32'h6400, 1, 32'h6304, 1, 32'h6400); // call+ret on empty

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 32'h3000);
    chk("reset_cnt", 32'(ras_count), 32'h0);
    chk("reset_empty", 32'(ras_empty), 32'h1);
    chk("reset_top", ras_top, 32'h0);
    chk("reset_pc_plus", pc_plus, 32'h3004);
    chk("reset_pc16", 32'(pc16), 32'hFFF8);
    reset = 0;

    // Table-driven main sequence
    for (int i = 0; i < tbl.size(); i++) begin
      en = tbl[i].en; redirect_valid = tbl[i].redir; redirect_pc = tbl[i].rpc;
      exc_valid = tbl[i].exc; eret_valid = tbl[i].eret; epc_in = tbl[i].epc;
      call = tbl[i].call; push_addr = tbl[i].paddr; ret = tbl[i].ret;
      step();
      chk($sformatf("v%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("v%0d_pc_plus", i), pc_plus, tbl[i].exp_pc + 32'd4);
      chk($sformatf("v%0d_cnt", i), 32'(ras_count), 32'(tbl[i].exp_cnt));
      chk($sformatf("v%0d_top", i), ras_top, tbl[i].exp_top);
      chk($sformatf("v%0d_empty", i), 32'(ras_empty), 32'(tbl[i].exp_cnt == '0));
    end

    // Asynchronous reset mid-cycle with a non-empty RAS and en high
    clear_inputs();
    en = 1;
    @(posedge clk);
    #3;
    reset = 1;
    #1;
    chk("async_pc", pc, 32'h3000);
    chk("async_cnt", 32'(ras_count), 32'h0);
    chk("async_empty", 32'(ras_empty), 32'h1);
    chk("async_top", ras_top, 32'h0);
    step();
    chk("reset_held_pc", pc, 32'h3000);
    reset = 0;
    step();
    chk("post_reset_pc", pc, 32'h3004);
    // Entries were cleared by reset: a call+ret pair on the fresh stack
    // must behave as a plain push.
    call = 1; ret = 1; push_addr = 32'h0000_7777;
    step();
    chk("post_reset_callret_pc", pc, 32'h3008);
    chk("post_reset_callret_top", ras_top, 32'h7777);
    clear_inputs();

    // 16-bit instance: wrap-around and call+ret replacement
    en16 = 1;
    step();
    chk("w16_pc_fffc", 32'(pc16), 32'hFFFC);
    chk("w16_pc_plus_wrap", 32'(pc_plus16), 32'h0000);
    step();
    chk("w16_pc_wrap", 32'(pc16), 32'h0000);
    call16 = 1; push_addr16 = 16'h0200;
    step();
    chk("w16_push_pc", 32'(pc16), 32'h0004);
    chk("w16_push_top", 32'(ras_top16), 32'h0200);
    push_addr16 = 16'h0100; ret16 = 1;
    step();
    chk("w16_callret_pc", 32'(pc16), 32'h0200);
    chk("w16_callret_top", 32'(ras_top16), 32'h0100);
    chk("w16_callret_cnt", 32'(ras_count16), 32'h1);
    call16 = 0; ret16 = 0; en16 = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
